ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
Synchronous responder for the CPU's RAM request/ready handshake. It serves two requesters: port A (stage12, instruction fetch) and port B (stage3, data access). Each transaction is a single-byte read or write to one single-port registered RAM, which has a 1-cycle read latency. Requesters are granted round-robin, and each completed transaction is acknowledged with a one-cycle ready pulse carrying read data.

Parameters:
ADDR_W, 16, address width of both ports and of the RAM.
DATA_W, 8, data width.
WAIT_CYCLES, 1, extra WAIT cycles after RAM address issue; minimum 1.

Ports:
ram_clk  in  1  sole clock; all logic on posedge.
rst  in  1  synchronous reset, active-low (asserted when 0).
a_req  in  1  port A request, level; held until a_ready.
a_we  in  1  port A write enable (1 = write, 0 = read).
a_addr  in  ADDR_W  port A address.
a_wdata  in  DATA_W  port A write data.
a_ready  out  1  one-cycle completion pulse for port A.
a_rdata  out  DATA_W  port A read data; valid when a_ready=1.
b_req, b_we, b_addr, b_wdata, b_ready, b_rdata: same as port A, for port B.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM registered read data.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 sampled at a posedge):
  - State goes to IDLE.
  - All outputs become 0: a_ready, b_ready, a_rdata, b_rdata, ram_we, ram_addr, ram_wdata, busy.
  - last_grant is set to B, so A wins the first tie.
- A reset that lands mid-transaction aborts it: no ready pulse is issued, and a pending write is not retried.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not in last_grant.
  - On grant: latch addr, we and wdata from the granted port; update last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - ram_addr and ram_wdata are driven from the latched values.
  - ram_we = latched we, high for exactly this one cycle.
  - Next state is WAIT.
- WAIT (WAIT_CYCLES cycles, counted by a down-counter):
  - ram_we = 0.
  - On the last WAIT cycle:
    - Reads: capture ram_rdata into the granted port's rdata.
    - Writes: leave rdata unchanged.
  - Next state is DONE.
- DONE (1 cycle):
  - The granted port's ready = 1; the other port's ready stays 0.
  - Next state is IDLE.
  - req is not sampled in DONE. A requester must drop req on seeing ready; a req that is still high in the following IDLE cycle counts as a new request.
- Latency: a req sampled in IDLE at edge N gives ready high during cycle N+2+WAIT_CYCLES (N+3 at the default). Next grant is possible at edge N+3+WAIT_CYCLES.
- Requester-side rules:
  - Changes to addr, we or wdata after the grant are ignored.
  - A non-granted req stays pending and is served in the next IDLE, with no loss.
  - Dropping req before ready does not cancel the transaction; ready still pulses.
- rdata holds its last value until the next read completion on that port.
- ram_addr holds its value outside ISSUE/WAIT.
- Address arithmetic is unsigned, with no wrap logic; the full 2^ADDR_W range is usable.
- The two readys are never high in the same cycle.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - port id constants PORT_A=0, PORT_B=1;
  - default ADDR_W and DATA_W.
- No sub-module. The 2-way round-robin pick is a few lines inside the FSM. The RAM stays an external instance.

Test Plan:
1. Reset, then RAM[0x0004]=0x01. A read 0x0004 sampled at edge N -> a_ready high only in cycle N+3, a_rdata=0x01, b_ready=0 throughout, ram_we never high.
2. B write 0x0010/0xA5, then A read 0x0010 -> ram_we high exactly 1 cycle with ram_addr=0x0010, ram_wdata=0xA5; b_rdata unchanged; then a_rdata=0xA5.
3. a_req and b_req both held high from reset release for four transactions -> grant order A,B,A,B; readys at N+3, N+7, N+11, N+15; never both high together.
4. A read granted at edge N, a_addr changed 0x0004->0x0008 at N+1 -> a_rdata=RAM[0x0004].
5. rst=0 during WAIT of an A read -> no a_ready pulse, all outputs 0 next cycle, busy=0; a subsequent B read completes normally at +3.
6. WAIT_CYCLES=3, A read sampled at edge N -> a_ready in cycle N+5; busy high for cycles N+1..N+5.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ram_arb_pkg
// Brief  : Shared state encoding, port ids and default widths for the arbiter.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ram_port_arbiter_if
// Brief  : Requester A/B handshakes plus the RAM-side bus of the arbiter.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ready;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ready;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ready, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ready, b_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ready, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ready, b_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ram_port_arbiter
// Brief  : Round-robin two-port responder in front of a 1-cycle registered RAM.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input wire                ram_clk,
    input wire                rst,
    ram_port_arbiter_if.slave bus
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              a_ready_q, a_ready_d;
    logic              b_ready_q, b_ready_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              grant_b;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        a_ready_d   = 1'b0;
        b_ready_d   = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        grant_b     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // On a tie the port that did not win last time gets the slot.
                    grant_b     = bus.b_req && (!bus.a_req || (last_q == PORT_A));
                    port_d      = grant_b;
                    last_d      = grant_b;
                    we_d        = grant_b ? bus.b_we    : bus.a_we;
                    ram_addr_d  = grant_b ? bus.b_addr  : bus.a_addr;
                    ram_wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
                    ram_we_d    = we_d;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (port_q == PORT_B) b_rdata_d = bus.ram_rdata;
                        else                  a_rdata_d = bus.ram_rdata;
                    end
                    a_ready_d = (port_q == PORT_A);
                    b_ready_d = (port_q == PORT_B);
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= PORT_B;
            port_q      <= PORT_A;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            a_ready_q   <= a_ready_d;
            b_ready_q   <= b_ready_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.a_ready   = a_ready_q;
    assign bus.b_ready   = b_ready_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire
